// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared types and constants for the I/D memory port arbiter
// Provides arb_state_t, owner encodings, the full-word write mask and WAIT_CYCLES range check.
package mem_port_arbiter_pkg;
  typedef enum logic {IDLE, BUSY} arb_state_t;
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;
  localparam logic [3:0] WE_ALL = 4'b1111;
  localparam int WAIT_MIN = 1;
  localparam int WAIT_MAX = 15;
  function automatic bit wait_ok(input int w);
    return w >= WAIT_MIN && w <= WAIT_MAX;
  endfunction
endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// arb_pick: one-hot grant selection between fetch (bit 0) and data (bit 1) requests
// Ports: fetch_req, data_req, ptr (owner with priority on a tie) in; gnt[1:0] one-hot out.
// A constant ptr of OWN_D gives fixed D-over-I priority; a registered ptr gives round robin.
module arb_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic       fetch_req,
  input  logic       data_req,
  input  logic       ptr,
  output logic [1:0] gnt
);
  logic win;
  always_comb begin
    win = (fetch_req && data_req) ? ptr : data_req;
    gnt = (fetch_req || data_req) ? (win == OWN_D ? 2'b10 : 2'b01) : 2'b00;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port word memory between instruction fetch and data access
// Ports: CLK, RST (sync active-high); I_REQ/I_ADDR -> I_GNT/I_RVALID/I_RDATA;
// D_REQ/D_WE/D_ADDR/D_WDATA -> D_GNT/D_RVALID/D_RDATA; memory side M_ADDR/M_DIN/M_WE, M_DOUT.
// Optional macro MEM_ARB_RR_EN: round-robin between I and D instead of fixed D priority.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              I_REQ,
  input  logic [ADDR_W-1:0] I_ADDR,
  output logic              I_GNT,
  output logic              I_RVALID,
  output logic [31:0]       I_RDATA,
  input  logic              D_REQ,
  input  logic              D_WE,
  input  logic [ADDR_W-1:0] D_ADDR,
  input  logic [31:0]       D_WDATA,
  output logic              D_GNT,
  output logic              D_RVALID,
  output logic [31:0]       D_RDATA,
  output logic [ADDR_W-1:0] M_ADDR,
  output logic [31:0]       M_DIN,
  output logic [3:0]        M_WE,
  input  logic [31:0]       M_DOUT
);
  if (!wait_ok(WAIT_CYCLES)) begin : g_wait_chk
    $error("WAIT_CYCLES must be within 1..15");
  end
  arb_state_t        state;
  logic              owner;
  logic              we;
  logic              ptr;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [1:0]        gnt;
  logic              take;
  logic              last;
  arb_pick u_pick (
    .fetch_req(I_REQ),
    .data_req (D_REQ),
    .ptr      (ptr),
    .gnt      (gnt)
  );
`ifndef MEM_ARB_RR_EN
  assign ptr = OWN_D;
`endif
  // grants are combinational in IDLE but suppressed while reset is applied
  assign take   = state == IDLE && !RST;
  assign last   = state == BUSY && cnt == 4'd0;
  assign I_GNT  = take && gnt[OWN_I];
  assign D_GNT  = take && gnt[OWN_D];
  assign M_ADDR = state == BUSY ? addr : '0;
  assign M_DIN  = state == BUSY ? wdata : '0;
  // reset in the final cycle must not let a write through
  assign M_WE   = (last && we && !RST) ? WE_ALL : 4'b0000;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= '0;
      owner    <= OWN_I;
      we       <= 1'b0;
      addr     <= '0;
      wdata    <= '0;
      I_RVALID <= 1'b0;
      D_RVALID <= 1'b0;
      I_RDATA  <= '0;
      D_RDATA  <= '0;
`ifdef MEM_ARB_RR_EN
      ptr      <= OWN_D;
`endif
    end else begin
      I_RVALID <= 1'b0;
      D_RVALID <= 1'b0;
      if (state == IDLE) begin
        if (|gnt) begin
          owner <= gnt[OWN_D];
          addr  <= gnt[OWN_D] ? D_ADDR : I_ADDR;
          we    <= gnt[OWN_D] && D_WE;
          wdata <= D_WDATA;
          cnt   <= 4'(WAIT_CYCLES - 1);
          state <= BUSY;
`ifdef MEM_ARB_RR_EN
          ptr   <= gnt[OWN_D] ? OWN_I : OWN_D;
`endif
        end
      end else if (cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end else begin
        state <= IDLE;
        if (owner == OWN_D) begin
          D_RVALID <= 1'b1;
          if (!we) D_RDATA <= M_DOUT;
        end else begin
          I_RVALID <= 1'b1;
          I_RDATA  <= M_DOUT;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter with WAIT_CYCLES=1 and =3 instances
module tb_mem_port_arbiter;
  localparam int W = 1;
  localparam int W3 = 3;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        I_REQ = 1'b0, D_REQ = 1'b0, D_WE = 1'b0;
  logic [31:0] I_ADDR = '0, D_ADDR = '0, D_WDATA = '0;
  logic        I_GNT, D_GNT, I_RVALID, D_RVALID;
  logic [31:0] I_RDATA, D_RDATA, M_ADDR, M_DIN, M_DOUT;
  logic [3:0]  M_WE;
  logic        d3_req = 1'b0;
  logic [31:0] d3_addr = '0;
  logic        i3_gnt, i3_rvalid, d3_gnt, d3_rvalid;
  logic [31:0] i3_rdata, d3_rdata, m3_addr, m3_din, m3_dout;
  logic [3:0]  m3_we;
  logic [31:0] mem [8192];
  logic [31:0] mem3 [8192];
  logic [31:0] shadow [8192];
  typedef struct {logic [31:0] data; int cyc;} exp_t;
  exp_t iq[$], dq[$], q3[$];
  logic glog[$];
  logic [31:0] last_d = '0;
  int vecs = 0, errs = 0, cyc = 0, we_cnt = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  mem_port_arbiter #(.WAIT_CYCLES(W), .ADDR_W(32)) dut (
    .CLK(CLK), .RST(RST),
    .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_GNT(I_GNT), .I_RVALID(I_RVALID), .I_RDATA(I_RDATA),
    .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
    .D_GNT(D_GNT), .D_RVALID(D_RVALID), .D_RDATA(D_RDATA),
    .M_ADDR(M_ADDR), .M_DIN(M_DIN), .M_WE(M_WE), .M_DOUT(M_DOUT)
  );
  mem_port_arbiter #(.WAIT_CYCLES(W3), .ADDR_W(32)) dut3 (
    .CLK(CLK), .RST(RST),
    .I_REQ(1'b0), .I_ADDR(32'd0), .I_GNT(i3_gnt), .I_RVALID(i3_rvalid), .I_RDATA(i3_rdata),
    .D_REQ(d3_req), .D_WE(1'b0), .D_ADDR(d3_addr), .D_WDATA(32'd0),
    .D_GNT(d3_gnt), .D_RVALID(d3_rvalid), .D_RDATA(d3_rdata),
    .M_ADDR(m3_addr), .M_DIN(m3_din), .M_WE(m3_we), .M_DOUT(m3_dout)
  );

  assign M_DOUT  = mem[M_ADDR[14:2]];
  assign m3_dout = mem3[m3_addr[14:2]];
  always @(posedge CLK) if (M_WE == 4'hF) mem[M_ADDR[14:2]] <= M_DIN;
  always @(posedge CLK) if (m3_we == 4'hF) mem3[m3_addr[14:2]] <= m3_din;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    vecs++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  always @(negedge CLK) begin : mon
    exp_t e;
    if (I_RVALID) begin
      if (iq.size() == 0) chk("i_spurious_rvalid", 32'd1, 32'd0);
      else begin
        e = iq.pop_front();
        chk("i_rdata", I_RDATA, e.data);
        chk("i_latency", 32'(cyc - e.cyc), 32'(W + 1));
      end
    end
    if (D_RVALID) begin
      if (dq.size() == 0) chk("d_spurious_rvalid", 32'd1, 32'd0);
      else begin
        e = dq.pop_front();
        chk("d_rdata", D_RDATA, e.data);
        chk("d_latency", 32'(cyc - e.cyc), 32'(W + 1));
      end
    end
    if (d3_rvalid) begin
      if (q3.size() == 0) chk("d3_spurious_rvalid", 32'd1, 32'd0);
      else begin
        e = q3.pop_front();
        chk("d3_rdata", d3_rdata, e.data);
        chk("d3_latency", 32'(cyc - e.cyc), 32'(W3 + 1));
      end
    end
    if (I_GNT || D_GNT) chk("one_gnt", 32'(I_GNT && D_GNT), 32'd0);
    if (I_RVALID || D_RVALID) chk("one_rvalid", 32'(I_RVALID && D_RVALID), 32'd0);
    if (I_GNT) begin
      iq.push_back('{shadow[I_ADDR[14:2]], cyc});
      glog.push_back(1'b0);
    end
    if (D_GNT) begin
      if (D_WE) shadow[D_ADDR[14:2]] = D_WDATA;
      else last_d = shadow[D_ADDR[14:2]];
      dq.push_back('{last_d, cyc});
      glog.push_back(1'b1);
    end
    if (d3_gnt) q3.push_back('{32'(d3_addr[14:2]) * 32'd10, cyc});
    if (M_WE != 4'h0) begin
      we_cnt++;
      chk("m_we_mask", 32'(M_WE), 32'hF);
    end
    if (RST) begin
      iq.delete();
      dq.delete();
      q3.delete();
      last_d = '0;
    end
  end

  task automatic i_fetch(input logic [31:0] a);
    int k;
    @(posedge CLK); #1;
    I_REQ = 1'b1; I_ADDR = a;
    k = 0;
    do begin @(negedge CLK); k++; end while (!I_GNT && k < 50);
    chk("i_gnt_wait", 32'(I_GNT), 32'd1);
    @(posedge CLK); #1 I_REQ = 1'b0;
  endtask

  task automatic d_access(input logic we, input logic [31:0] a, input logic [31:0] wd);
    int k;
    @(posedge CLK); #1;
    D_REQ = 1'b1; D_WE = we; D_ADDR = a; D_WDATA = wd;
    k = 0;
    do begin @(negedge CLK); k++; end while (!D_GNT && k < 50);
    chk("d_gnt_wait", 32'(D_GNT), 32'd1);
    @(posedge CLK); #1 D_REQ = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_i_gnt"}, 32'(I_GNT), 32'd0);
    chk({tag, "_d_gnt"}, 32'(D_GNT), 32'd0);
    chk({tag, "_i_rvalid"}, 32'(I_RVALID), 32'd0);
    chk({tag, "_d_rvalid"}, 32'(D_RVALID), 32'd0);
    chk({tag, "_i_rdata"}, I_RDATA, 32'd0);
    chk({tag, "_d_rdata"}, D_RDATA, 32'd0);
    chk({tag, "_m_addr"}, M_ADDR, 32'd0);
    chk({tag, "_m_din"}, M_DIN, 32'd0);
    chk({tag, "_m_we"}, 32'(M_WE), 32'd0);
  endtask

  initial begin
    int we0, n, k;
    logic [3:0] pat;
    for (int i = 0; i < 8192; i++) begin
      mem[i] = 32'(i) * 32'd10;
      mem3[i] = 32'(i) * 32'd10;
      shadow[i] = 32'(i) * 32'd10;
    end
    I_REQ = 1'b1; D_REQ = 1'b1;
    idle(2);
    @(negedge CLK);
    chk_zero("reset");
    @(posedge CLK); #1;
    I_REQ = 1'b0; D_REQ = 1'b0; RST = 1'b0;

    we0 = we_cnt;
    i_fetch(32'h8);
    idle(3);
    chk("fetch_no_write", 32'(we_cnt - we0), 32'd0);

    d_access(1'b0, 32'h8006, '0);
    idle(3);

    we0 = we_cnt;
    d_access(1'b1, 32'h4, 32'hABCD);
    idle(3);
    chk("store_we_cycles", 32'(we_cnt - we0), 32'd1);
    d_access(1'b0, 32'h4, '0);
    idle(3);

    @(posedge CLK); #1 RST = 1'b1;
    @(posedge CLK); #1 RST = 1'b0;
    glog.delete();
    I_REQ = 1'b1; I_ADDR = 32'h0; D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 32'hC;
    n = 0; k = 0;
    while (n < 4 && k < 100) begin
      @(negedge CLK); k++;
      if (I_GNT || D_GNT) n++;
    end
    chk("both_grants", 32'(n), 32'd4);
    @(posedge CLK); #1 I_REQ = 1'b0; D_REQ = 1'b0;
    idle(3);
`ifdef MEM_ARB_RR_EN
    pat = 4'b0101;
`else
    pat = 4'b1111;
`endif
    chk("both_glog_len", 32'(glog.size()), 32'd4);
    for (int j = 0; j < 4 && j < glog.size(); j++) chk($sformatf("both_owner%0d", j), 32'(glog[j]), 32'(pat[j]));

    @(posedge CLK); #1;
    D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 32'h10; D_WDATA = 32'hDEAD;
    k = 0;
    do begin @(negedge CLK); k++; end while (!D_GNT && k < 50);
    chk("rst_store_gnt", 32'(D_GNT), 32'd1);
    @(posedge CLK); #1 D_REQ = 1'b0; RST = 1'b1;
    @(negedge CLK);
    chk("rst_final_m_we", 32'(M_WE), 32'd0);
    @(posedge CLK); #1 RST = 1'b0;
    shadow[4] = 32'd40;
    @(negedge CLK);
    chk_zero("abort");
    chk("abort_mem4", mem[4], 32'd40);
    d_access(1'b0, 32'h10, '0);
    idle(3);

    @(posedge CLK); #1 d3_req = 1'b1; d3_addr = 32'h10;
    k = 0;
    do begin @(negedge CLK); k++; end while (!d3_gnt && k < 50);
    chk("w3_gnt_wait", 32'(d3_gnt), 32'd1);
    @(posedge CLK); #1 d3_addr = 32'h14;
    for (int j = 0; j < 3; j++) begin
      if (j > 0) @(posedge CLK);
      @(negedge CLK);
      chk("w3_m_addr_a", m3_addr, 32'h10);
      chk("w3_no_gnt_busy", 32'(d3_gnt), 32'd0);
    end
    @(negedge CLK);
    chk("w3_gnt_spacing", 32'(d3_gnt), 32'd1);
    chk("w3_rvalid_a", 32'(d3_rvalid), 32'd1);
    @(posedge CLK); #1 d3_req = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge CLK);
      chk("w3_m_addr_b", m3_addr, 32'h14);
    end
    @(negedge CLK);
    chk("w3_rvalid_b", 32'(d3_rvalid), 32'd1);
    chk("w3_no_regrant", 32'(d3_gnt), 32'd0);

    idle(6);
    chk("iq_drained", 32'(iq.size()), 32'd0);
    chk("dq_drained", 32'(dq.size()), 32'd0);
    chk("q3_drained", 32'(q3.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
